// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling window feeder.
package pool_pkg;
   localparam int DW_DEF   = 16;
   localparam int WIN_COLS = 4;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_COLLECT,
      ST_ISSUE,
      ST_WAIT
   } state_e;
endpackage

// File: rtl/pool_window_feeder_if.sv
// Pixel stream, per-frame config and the 2x4 window/handshake toward the pooling unit.
interface pool_window_feeder_if
   import pool_pkg::*;
#(
   parameter int DW = DW_DEF
) ();
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          cfg_size1, cfg_size2, cfg_pool_sel;
   logic          size1, size2, pool_sel;
   logic [DW-1:0] d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7;
   logic          start, en, done, frame_done;

   modport master (
      input  s_valid, s_data, cfg_size1, cfg_size2, cfg_pool_sel, done,
      output s_ready, size1, size2, pool_sel,
             d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7, start, en, frame_done
   );

   modport slave (
      output s_valid, s_data, cfg_size1, cfg_size2, cfg_pool_sel, done,
      input  s_ready, size1, size2, pool_sel,
             d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7, start, en, frame_done
   );
endinterface

// File: rtl/pool_line_buffer.sv
// One-row line buffer: register array, one synchronous write port, one async read port.
module pool_line_buffer #(
   parameter  int DW    = 16,
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);
   // Contents are intentionally not reset; every entry is rewritten before it is read.
   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pool_window_feeder.sv
// Buffers an even row, pairs it with 4-column slices of the next odd row and hands
// each 2x4 window to the pooling unit with a start/en/done handshake.
module pool_window_feeder
   import pool_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int IMG_W = 32,
   parameter int IMG_H = 32
) (
   input logic                 clk,
   input logic                 rst_fsm,
   pool_window_feeder_if.master pw
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

   state_e                        state_q;
   logic [CW-1:0]                 col_q, col_d;
   logic [RW-1:0]                 row_q, row_d;
   logic [WIN_COLS-1:0][DW-1:0]   top_q, bot_q;
   logic [WIN_COLS-1:0][DW-1:0]   win_top_q, win_bot_q;
   logic [WIN_COLS-1:0][DW-1:0]   win_top_d, win_bot_d;
   logic                          start_q, en_q, fd_q;
   logic                          size1_q, size2_q, pool_sel_q;
   logic [DW-1:0]                 lb_rdata;
   logic [1:0]                    slot;
   logic                          accept, col_last, row_last;

   assign pw.s_ready = (state_q == ST_FILL || state_q == ST_COLLECT) && !rst_fsm;
   assign accept     = pw.s_valid && pw.s_ready;
   assign slot       = col_q[1:0];
   assign col_last   = (col_q == CW'(IMG_W - 1));
   assign row_last   = (row_q == RW'(IMG_H - 1));
   assign col_d      = col_last ? '0 : col_q + 1'b1;
   assign row_d      = row_last ? '0 : row_q + 1'b1;

   pool_line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_lb (
      .clk     (clk),
      .we_i    (accept && state_q == ST_FILL),
      .waddr_i (col_q),
      .wdata_i (pw.s_data),
      .raddr_i (col_q),
      .rdata_o (lb_rdata)
   );

   // The 4th pixel of a slice bypasses the stage regs so the window lands with start.
   always_comb begin
      win_top_d    = top_q;
      win_bot_d    = bot_q;
      win_top_d[3] = lb_rdata;
      win_bot_d[3] = pw.s_data;
   end

   always_ff @(posedge clk) begin
      if (rst_fsm) begin
         state_q    <= ST_FILL;
         col_q      <= '0;
         row_q      <= '0;
         top_q      <= '0;
         bot_q      <= '0;
         win_top_q  <= '0;
         win_bot_q  <= '0;
         start_q    <= 1'b0;
         en_q       <= 1'b0;
         fd_q       <= 1'b0;
         size1_q    <= 1'b0;
         size2_q    <= 1'b0;
         pool_sel_q <= 1'b0;
      end else begin
         start_q <= 1'b0;
         fd_q    <= 1'b0;
         case (state_q)
            ST_FILL: if (accept) begin
               if (row_q == '0 && col_q == '0) begin
                  size1_q    <= pw.cfg_size1;
                  size2_q    <= pw.cfg_size2;
                  pool_sel_q <= pw.cfg_pool_sel;
               end
               col_q <= col_d;
               if (col_last) begin
                  row_q   <= row_d;
                  state_q <= ST_COLLECT;
               end
            end
            ST_COLLECT: if (accept) begin
               top_q[slot] <= lb_rdata;
               bot_q[slot] <= pw.s_data;
               col_q       <= col_d;
               if (slot == 2'd3) begin
                  win_top_q <= win_top_d;
                  win_bot_q <= win_bot_d;
                  start_q   <= 1'b1;
                  en_q      <= 1'b1;
                  state_q   <= ST_ISSUE;
               end
            end
            ST_ISSUE: state_q <= ST_WAIT;
            ST_WAIT: if (pw.done) begin
               en_q <= 1'b0;
               // col already wrapped to 0 means that was the row's last slice
               if (col_q == '0) begin
                  row_q   <= row_d;
                  fd_q    <= row_last;
                  state_q <= ST_FILL;
               end else begin
                  state_q <= ST_COLLECT;
               end
            end
            default: state_q <= ST_FILL;
         endcase
      end
   end

   assign pw.d_0        = win_top_q[0];
   assign pw.d_1        = win_top_q[1];
   assign pw.d_2        = win_top_q[2];
   assign pw.d_3        = win_top_q[3];
   assign pw.d_4        = win_bot_q[0];
   assign pw.d_5        = win_bot_q[1];
   assign pw.d_6        = win_bot_q[2];
   assign pw.d_7        = win_bot_q[3];
   assign pw.start      = start_q;
   assign pw.en         = en_q;
   assign pw.frame_done = fd_q;
   assign pw.size1      = size1_q;
   assign pw.size2      = size2_q;
   assign pw.pool_sel   = pool_sel_q;
endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder on an 8x4 frame with pixel(r,c)=16*r+c.
module tb_pool_window_feeder;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst_fsm;
   always #5 clk = ~clk;

   pool_window_feeder_if #(.DW(DW)) pif ();

   pool_window_feeder #(.DW(DW), .IMG_W(8), .IMG_H(4)) dut (
      .clk     (clk),
      .rst_fsm (rst_fsm),
      .pw      (pif)
   );

   logic done_auto, done_man;
   assign pif.done = done_auto | done_man;

   int   n_tests, n_fail;
   int   cyc, idx, src_end, acc_cnt, win_cnt, fd_cnt, dcnt, acc11_cyc;
   bit   pend, src_on, auto_done, track, psel_bad, en_acc_bad;
   logic [DW-1:0] wtop [8][4];
   logic [DW-1:0] wbot [8][4];
   int   en_len [8];
   int   start_cyc [8];

   function automatic logic [DW-1:0] pix(int i);
      return DW'(16 * ((i / 8) % 4) + (i % 8));
   endfunction

   // One clock: observe at the falling edge, drive the next inputs, then note the handshake.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (pend) begin idx++; acc_cnt++; end
      if (pif.start) begin
         if (win_cnt < 8) begin
            wtop[win_cnt] = '{pif.d_0, pif.d_1, pif.d_2, pif.d_3};
            wbot[win_cnt] = '{pif.d_4, pif.d_5, pif.d_6, pif.d_7};
            start_cyc[win_cnt] = cyc;
         end
         win_cnt++;
      end
      if (pif.en && win_cnt > 0 && win_cnt <= 8) en_len[win_cnt-1]++;
      if (pif.frame_done) fd_cnt++;
      if (track && pif.pool_sel !== 1'b1) psel_bad = 1;
      if (dcnt > 0) begin
         dcnt--;
         done_auto = auto_done && (dcnt == 0);
      end else begin
         done_auto = 1'b0;
      end
      if (pif.start) dcnt = 3;
      if (src_on && idx < src_end) begin
         pif.s_valid = 1'b1;
         pif.s_data  = pix(idx);
      end else begin
         pif.s_valid = 1'b0;
      end
      #1;
      pend = pif.s_valid && pif.s_ready;
      if (pend && idx == 11) acc11_cyc = cyc;
      if (pend && pif.en) en_acc_bad = 1;
   endtask

   task automatic clear_stats();
      acc_cnt = 0; win_cnt = 0; fd_cnt = 0;
      for (int w = 0; w < 8; w++) begin en_len[w] = 0; start_cyc[w] = 0; end
   endtask

   task automatic test_reset();
      rst_fsm = 1'b1;
      tick(); tick(); tick();
      n_tests++;
      if ({pif.start, pif.en, pif.frame_done} !== 3'b000) begin
         n_fail++; $display("FAIL reset_ctrl got=%b want=000", {pif.start, pif.en, pif.frame_done});
      end
      n_tests++;
      if ({pif.size1, pif.size2, pif.pool_sel} !== 3'b000) begin
         n_fail++; $display("FAIL reset_cfg got=%b want=000", {pif.size1, pif.size2, pif.pool_sel});
      end
      n_tests++;
      if ({pif.d_0, pif.d_1, pif.d_2, pif.d_3, pif.d_4, pif.d_5, pif.d_6, pif.d_7} !== '0) begin
         n_fail++; $display("FAIL reset_window got=%h want=0",
            {pif.d_0, pif.d_1, pif.d_2, pif.d_3, pif.d_4, pif.d_5, pif.d_6, pif.d_7});
      end
      n_tests++;
      if (pif.s_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_s_ready got=%b want=0", pif.s_ready);
      end
      rst_fsm = 1'b0;
      tick();
      n_tests++;
      if (pif.s_ready !== 1'b1) begin
         n_fail++; $display("FAIL release_s_ready got=%b want=1", pif.s_ready);
      end
   endtask

   task automatic test_frame();
      logic [8*DW-1:0] got, exp;
      int r, c;
      pif.cfg_size1 = 1'b1; pif.cfg_size2 = 1'b0; pif.cfg_pool_sel = 1'b1;
      clear_stats();
      idx = 0; src_end = 32; src_on = 1; auto_done = 1; en_acc_bad = 0; psel_bad = 0;
      for (int i = 0; i < 150 && fd_cnt == 0; i++) begin
         tick();
         if (i == 20) begin pif.cfg_pool_sel = 1'b0; track = 1; end
      end
      for (int i = 0; i < 6; i++) tick();
      track = 0;
      n_tests++;
      if (fd_cnt !== 1) begin n_fail++; $display("FAIL frame_done_pulses got=%0d want=1", fd_cnt); end
      n_tests++;
      if (win_cnt !== 4) begin n_fail++; $display("FAIL window_count got=%0d want=4", win_cnt); end
      n_tests++;
      if (acc_cnt !== 32) begin n_fail++; $display("FAIL accepted got=%0d want=32", acc_cnt); end
      n_tests++;
      if (start_cyc[0] !== acc11_cyc + 1) begin
         n_fail++; $display("FAIL start_latency got=%0d want=%0d", start_cyc[0], acc11_cyc + 1);
      end
      for (int w = 0; w < 4; w++) begin
         r = 2 * (w / 2); c = 4 * (w % 2);
         for (int k = 0; k < 4; k++) begin
            got[(7-k)*DW +: DW]   = wtop[w][k];
            got[(3-k)*DW +: DW]   = wbot[w][k];
            exp[(7-k)*DW +: DW]   = DW'(16 * r + c + k);
            exp[(3-k)*DW +: DW]   = DW'(16 * (r + 1) + c + k);
         end
         n_tests++;
         if (got !== exp) begin n_fail++; $display("FAIL window%0d got=%h want=%h", w, got, exp); end
         n_tests++;
         if (en_len[w] !== 4) begin n_fail++; $display("FAIL en_len%0d got=%0d want=4", w, en_len[w]); end
      end
      n_tests++;
      if (en_acc_bad !== 1'b0) begin n_fail++; $display("FAIL accept_while_en got=1 want=0"); end
      n_tests++;
      if (psel_bad !== 1'b0) begin n_fail++; $display("FAIL pool_sel_midframe got=changed want=held_1"); end
   endtask

   task automatic test_cfg_latch();
      pif.cfg_size1 = 1'b0; pif.cfg_size2 = 1'b1; pif.cfg_pool_sel = 1'b0;
      n_tests++;
      if ({pif.size1, pif.size2, pif.pool_sel} !== 3'b101) begin
         n_fail++; $display("FAIL cfg_before_frame got=%b want=101", {pif.size1, pif.size2, pif.pool_sel});
      end
      clear_stats();
      idx = 0; src_end = 12; auto_done = 0;
      tick(); tick();
      n_tests++;
      if ({pif.size1, pif.size2, pif.pool_sel} !== 3'b010) begin
         n_fail++; $display("FAIL cfg_latched got=%b want=010", {pif.size1, pif.size2, pif.pool_sel});
      end
   endtask

   task automatic test_done_in_issue();
      for (int i = 0; i < 40 && win_cnt == 0; i++) tick();
      n_tests++;
      if ({pif.start, pif.d_0, pif.d_3, pif.d_4, pif.d_7} !== {1'b1, 16'd0, 16'd3, 16'd16, 16'd19}) begin
         n_fail++; $display("FAIL issue_window got=%b/%0d/%0d/%0d/%0d want=1/0/3/16/19",
            pif.start, pif.d_0, pif.d_3, pif.d_4, pif.d_7);
      end
      done_man = 1'b1;
      tick();
      done_man = 1'b0;
      n_tests++;
      if ({pif.en, pif.start} !== 2'b10) begin
         n_fail++; $display("FAIL done_in_issue en,start got=%b want=10", {pif.en, pif.start});
      end
      tick(); tick(); tick();
      n_tests++;
      if (pif.en !== 1'b1) begin n_fail++; $display("FAIL en_held got=%b want=1", pif.en); end
      done_man = 1'b1;
      tick();
      done_man = 1'b0;
      n_tests++;
      if ({pif.en, pif.s_ready} !== 2'b01) begin
         n_fail++; $display("FAIL done_in_wait en,s_ready got=%b want=01", {pif.en, pif.s_ready});
      end
   endtask

   task automatic test_reset_in_wait();
      src_end = 16;
      for (int i = 0; i < 40 && win_cnt < 2; i++) tick();
      tick();
      n_tests++;
      if (pif.en !== 1'b1) begin n_fail++; $display("FAIL wait_en got=%b want=1", pif.en); end
      rst_fsm = 1'b1;
      tick();
      n_tests++;
      if ({pif.en, pif.s_ready, pif.d_0} !== {1'b0, 1'b0, 16'd0}) begin
         n_fail++; $display("FAIL rst_in_wait en,s_ready,d_0 got=%b,%b,%0d want=0,0,0",
            pif.en, pif.s_ready, pif.d_0);
      end
      rst_fsm = 1'b0;
      tick();
      n_tests++;
      if (pif.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_s_ready got=%b want=1", pif.s_ready); end
      clear_stats();
      idx = 0; src_end = 32; auto_done = 1;
      for (int i = 0; i < 150 && fd_cnt == 0; i++) tick();
      n_tests++;
      if ({win_cnt, acc_cnt, fd_cnt} !== {32'd4, 32'd32, 32'd1}) begin
         n_fail++; $display("FAIL restart_frame win,acc,fd got=%0d,%0d,%0d want=4,32,1", win_cnt, acc_cnt, fd_cnt);
      end
      n_tests++;
      if ({wtop[0][0], wbot[0][3], wtop[3][0], wbot[3][3]} !== {16'd0, 16'd19, 16'd36, 16'd55}) begin
         n_fail++; $display("FAIL restart_windows got=%0d,%0d,%0d,%0d want=0,19,36,55",
            wtop[0][0], wbot[0][3], wtop[3][0], wbot[3][3]);
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; idx = 0; src_end = 0; dcnt = 0; acc11_cyc = -10;
      pend = 0; src_on = 0; auto_done = 0; track = 0; psel_bad = 0; en_acc_bad = 0;
      done_auto = 1'b0; done_man = 1'b0; rst_fsm = 1'b1;
      pif.s_valid = 1'b0; pif.s_data = '0;
      pif.cfg_size1 = 1'b0; pif.cfg_size2 = 1'b0; pif.cfg_pool_sel = 1'b0;
      clear_stats();
      test_reset();
      test_frame();
      test_cfg_latch();
      test_done_in_issue();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end
endmodule
